// File: rtl/iltype_decode_tracker_pkg.sv
// Shared constants and decode classification for the I-type decode tracker.
// Holds the opcode/NOP/funct7 constants and the decode class enumeration.
package iltype_decode_tracker_pkg;

    localparam logic [6:0]  OpcAluImm  = 7'b0010011;
    localparam logic [6:0]  OpcLoad    = 7'b0000011;
    localparam logic [31:0] NopWord    = 32'h0000_0013;
    localparam logic [6:0]  Funct7Zero = 7'b0000000;
    localparam logic [6:0]  Funct7Alt  = 7'b0100000;

    typedef enum logic [1:0] {
        ClsNop     = 2'd0,
        ClsAlui    = 2'd1,
        ClsLoad    = 2'd2,
        ClsIllegal = 2'd3
    } dec_class_e;

    function automatic dec_class_e classify(input logic [31:0] word);
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        dec_class_e cls;
        opcode = word[6:0];
        funct3 = word[14:12];
        funct7 = word[31:25];
        cls    = ClsIllegal;
        if (word == NopWord) begin
            cls = ClsNop;
        end else if (opcode == OpcAluImm) begin
            unique case (funct3)
                3'd1:    cls = (funct7 == Funct7Zero) ? ClsAlui : ClsIllegal;
                3'd5:    cls = (funct7 == Funct7Zero || funct7 == Funct7Alt) ? ClsAlui : ClsIllegal;
                default: cls = ClsAlui;
            endcase
        end else if (opcode == OpcLoad) begin
            unique case (funct3)
                3'd3, 3'd6, 3'd7: cls = ClsIllegal;
                default:          cls = ClsLoad;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/iltype_decode_tracker_if.sv
// Bundles the fetch, retire and status signals of the decode tracker.
// The slave modport is the tracker's view; master is the driver's view.
interface iltype_decode_tracker_if
    import iltype_decode_tracker_pkg::*;
#(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic             instr_valid;
    logic [31:0]      instr;
    logic             retire_valid;
    logic             retire_wen;
    logic [4:0]       retire_rd;

    logic             dec_valid;
    dec_class_e       dec_class;
    logic [4:0]       dec_rd;
    logic [4:0]       dec_rs1;
    logic [2:0]       dec_funct3;
    logic [31:0]      dec_imm;

    logic [CntW-1:0]  q_count;
    logic             q_full;
    logic             q_empty;
    logic             mismatch;
    logic             overflow;
    logic             underflow;
    logic [15:0]      illegal_cnt;
    logic [31:0]      retired_cnt;

    modport slave (
        input  instr_valid, instr, retire_valid, retire_wen, retire_rd,
        output dec_valid, dec_class, dec_rd, dec_rs1, dec_funct3, dec_imm,
        output q_count, q_full, q_empty, mismatch, overflow, underflow,
        output illegal_cnt, retired_cnt
    );

    modport master (
        output instr_valid, instr, retire_valid, retire_wen, retire_rd,
        input  dec_valid, dec_class, dec_rd, dec_rs1, dec_funct3, dec_imm,
        input  q_count, q_full, q_empty, mismatch, overflow, underflow,
        input  illegal_cnt, retired_cnt
    );

endinterface

// File: rtl/iltype_decode_tracker_rd_fifo.sv
// Expected-writeback FIFO of destination registers. A pop is judged against
// occupancy before a same-cycle push, so push+pop on a full queue both occur.
module rd_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [4:0]               wdata,
    output logic [4:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     pop_ok,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [4:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q;
    logic            push_ok;

    assign count     = count_q;
    assign full      = (count_q == CntW'(DEPTH));
    assign empty     = (count_q == '0);
    assign head      = mem_q[rptr_q];
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign overflow  = push && full && !pop_ok;
    assign underflow = pop && empty;

    always_ff @(posedge clk) begin
        if (reset && push_ok) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + PtrW'(1);
            if (pop_ok)  rptr_q <= rptr_q + PtrW'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/iltype_decode_tracker.sv
// One-cycle registered I-type/load decoder that queues expected writeback
// destinations and checks them against retirement order.
module iltype_decode_tracker
    import iltype_decode_tracker_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input logic                   clk,
    input logic                   reset,
    iltype_decode_tracker_if.slave bus
);
    logic        dec_valid_q;
    dec_class_e  dec_class_q;
    logic [4:0]  dec_rd_q, dec_rs1_q;
    logic [2:0]  dec_funct3_q;
    logic [31:0] dec_imm_q;
    logic        mismatch_q, overflow_q, underflow_q;
    logic [15:0] illegal_cnt_q;
    logic [31:0] retired_cnt_q;

    logic        push, pop;
    logic [4:0]  head;
    logic        pop_ok, fifo_overflow, fifo_underflow;
    logic        q_full, q_empty;
    logic [$clog2(DEPTH):0] q_count;

    // Pushes come from the registered decode stage, not the raw fetch word.
    assign push = dec_valid_q && (dec_class_q == ClsAlui || dec_class_q == ClsLoad)
                  && (dec_rd_q != 5'd0);
    assign pop  = bus.retire_valid && bus.retire_wen && (bus.retire_rd != 5'd0);

    rd_fifo #(
        .DEPTH (DEPTH)
    ) u_rd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .wdata     (dec_rd_q),
        .head      (head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty),
        .pop_ok    (pop_ok),
        .overflow  (fifo_overflow),
        .underflow (fifo_underflow)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            dec_valid_q   <= 1'b0;
            dec_class_q   <= ClsNop;
            dec_rd_q      <= '0;
            dec_rs1_q     <= '0;
            dec_funct3_q  <= '0;
            dec_imm_q     <= '0;
            mismatch_q    <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            illegal_cnt_q <= '0;
            retired_cnt_q <= '0;
        end else begin
            dec_valid_q  <= bus.instr_valid;
            dec_class_q  <= classify(bus.instr);
            dec_rd_q     <= bus.instr[11:7];
            dec_rs1_q    <= bus.instr[19:15];
            dec_funct3_q <= bus.instr[14:12];
            dec_imm_q    <= {{20{bus.instr[31]}}, bus.instr[31:20]};

            if (dec_valid_q && dec_class_q == ClsIllegal && illegal_cnt_q != 16'hFFFF) begin
                illegal_cnt_q <= illegal_cnt_q + 16'd1;
            end
            if (pop_ok) begin
                retired_cnt_q <= retired_cnt_q + 32'd1;
                if (head != bus.retire_rd) mismatch_q <= 1'b1;
            end
            if (fifo_overflow)  overflow_q  <= 1'b1;
            if (fifo_underflow) underflow_q <= 1'b1;
        end
    end

    assign bus.dec_valid   = dec_valid_q;
    assign bus.dec_class   = dec_class_q;
    assign bus.dec_rd      = dec_rd_q;
    assign bus.dec_rs1     = dec_rs1_q;
    assign bus.dec_funct3  = dec_funct3_q;
    assign bus.dec_imm     = dec_imm_q;
    assign bus.q_count     = q_count;
    assign bus.q_full      = q_full;
    assign bus.q_empty     = q_empty;
    assign bus.mismatch    = mismatch_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
    assign bus.illegal_cnt = illegal_cnt_q;
    assign bus.retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_iltype_decode_tracker.sv
// Directed plus randomized bench for iltype_decode_tracker, compared every
// cycle against a queue-based reference model.
module tb_iltype_decode_tracker;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    iltype_decode_tracker_if #(.DEPTH(DEPTH)) bus ();

    iltype_decode_tracker #(
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model state
    logic [4:0]  m_q[$];
    logic        m_dvalid;
    int          m_cls;
    logic [31:0] m_word;
    logic        m_mismatch, m_overflow, m_underflow;
    int          m_illegal;
    logic [31:0] m_retired;

    function automatic int ref_class(input logic [31:0] w);
        int op, f3, hi7;
        op  = int'(w[6:0]);
        f3  = int'(w[14:12]);
        hi7 = int'(w[31:25]);
        if (w == 32'h13) return 0;
        if (op == 'h13) begin
            if (f3 == 1 && hi7 != 0) return 3;
            if (f3 == 5 && hi7 != 0 && hi7 != 'h20) return 3;
            return 1;
        end
        if (op == 'h03) return (f3 == 3 || f3 == 6 || f3 == 7) ? 3 : 2;
        return 3;
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit do_pop, do_push;
        logic [4:0] h;
        if (!reset) begin
            m_q.delete();
            m_dvalid = 1'b0; m_cls = 0; m_word = '0;
            m_mismatch = 1'b0; m_overflow = 1'b0; m_underflow = 1'b0;
            m_illegal = 0; m_retired = '0;
            return;
        end
        do_pop  = bus.retire_valid && bus.retire_wen && bus.retire_rd != 0;
        do_push = m_dvalid && (m_cls == 1 || m_cls == 2) && m_word[11:7] != 0;
        if (do_pop) begin
            if (m_q.size() == 0) m_underflow = 1'b1;
            else begin
                h = m_q.pop_front();
                m_retired = m_retired + 1;
                if (h != bus.retire_rd) m_mismatch = 1'b1;
            end
        end
        if (do_push) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_word[11:7]);
            else m_overflow = 1'b1;
        end
        if (m_dvalid && m_cls == 3 && m_illegal < 'hFFFF) m_illegal++;
        m_dvalid = bus.instr_valid;
        m_word   = bus.instr;
        m_cls    = ref_class(bus.instr);
    endtask

    task automatic compare_all();
        logic [31:0] imm_exp;
        imm_exp = 32'($signed(m_word[31:20]));
        chk("dec_valid",   32'(bus.dec_valid),   32'(m_dvalid));
        chk("dec_class",   32'(bus.dec_class),   32'(m_cls));
        chk("dec_rd",      32'(bus.dec_rd),      32'(m_word[11:7]));
        chk("dec_rs1",     32'(bus.dec_rs1),     32'(m_word[19:15]));
        chk("dec_funct3",  32'(bus.dec_funct3),  32'(m_word[14:12]));
        chk("dec_imm",     bus.dec_imm,          imm_exp);
        chk("q_count",     32'(bus.q_count),     32'(m_q.size()));
        chk("q_full",      32'(bus.q_full),      32'(m_q.size() == DEPTH));
        chk("q_empty",     32'(bus.q_empty),     32'(m_q.size() == 0));
        chk("mismatch",    32'(bus.mismatch),    32'(m_mismatch));
        chk("overflow",    32'(bus.overflow),    32'(m_overflow));
        chk("underflow",   32'(bus.underflow),   32'(m_underflow));
        chk("illegal_cnt", 32'(bus.illegal_cnt), 32'(m_illegal));
        chk("retired_cnt", bus.retired_cnt,      m_retired);
    endtask

    task automatic drive(input logic iv, input logic [31:0] w, input logic rv,
                         input logic rwen, input logic [4:0] rrd);
        bus.instr_valid  = iv;
        bus.instr        = w;
        bus.retire_valid = rv;
        bus.retire_wen   = rwen;
        bus.retire_rd    = rrd;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
        tick();
    endtask

    task automatic retire(input logic [4:0] rd);
        drive(1'b0, 32'h0, 1'b1, 1'b1, rd);
        tick();
    endtask

    task automatic fetch(input logic [31:0] w);
        drive(1'b1, w, 1'b0, 1'b0, 5'd0);
        tick();
    endtask

    initial begin
        logic [31:0] w;
        logic [6:0]  hi;
        int          sel;

        reset = 1'b0;
        drive(1'b1, 32'h00A28293, 1'b1, 1'b1, 5'd3);
        tick();
        tick();
        chk("rst_q_empty", 32'(bus.q_empty), 32'd1);
        chk("rst_class", 32'(bus.dec_class), 32'd0);
        reset = 1'b1;
        idle_tick();

        // NOP does not queue
        fetch(32'h00000013);
        chk("nop_class", 32'(bus.dec_class), 32'd0);
        idle_tick();
        chk("nop_qcount", 32'(bus.q_count), 32'd0);

        // addi x5, x5, 10 then matching retire
        fetch(32'h00A28293);
        chk("addi_class", 32'(bus.dec_class), 32'd1);
        chk("addi_imm", bus.dec_imm, 32'h0000000A);
        idle_tick();
        chk("addi_qcount", 32'(bus.q_count), 32'd1);
        retire(5'd5);
        chk("addi_retired", bus.retired_cnt, 32'd1);
        chk("addi_nomismatch", 32'(bus.mismatch), 32'd0);

        // lw x6, -4(x1) then mismatched retire
        fetch(32'hFFC0A303);
        chk("lw_class", 32'(bus.dec_class), 32'd2);
        chk("lw_imm", bus.dec_imm, 32'hFFFFFFFC);
        idle_tick();
        retire(5'd7);
        chk("lw_mismatch", 32'(bus.mismatch), 32'd1);
        idle_tick();
        chk("lw_mismatch_sticky", 32'(bus.mismatch), 32'd1);

        // illegal shift and illegal load width
        fetch(32'h02001093);
        fetch(32'h00006003);
        idle_tick();
        chk("illegal_cnt2", 32'(bus.illegal_cnt), 32'd2);
        chk("illegal_nopush", 32'(bus.q_count), 32'd0);

        reset = 1'b0;
        idle_tick();
        reset = 1'b1;

        // overflow then drain in order then underflow
        for (int i = 1; i <= 5; i++) fetch(enc_i(12'd1, 5'd0, 3'd0, 5'(i), 7'h13));
        idle_tick();
        chk("ovf_full", 32'(bus.q_full), 32'd1);
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
        for (int i = 1; i <= 4; i++) retire(5'(i));
        chk("drain_nomismatch", 32'(bus.mismatch), 32'd0);
        retire(5'd9);
        chk("udf_flag", 32'(bus.underflow), 32'd1);

        // reset discards queued entries
        fetch(enc_i(12'd0, 5'd1, 3'd0, 5'd9, 7'h13));
        fetch(enc_i(12'd0, 5'd1, 3'd0, 5'd10, 7'h13));
        idle_tick();
        chk("pre_rst_qcount", 32'(bus.q_count), 32'd2);
        reset = 1'b0;
        fetch(enc_i(12'd0, 5'd1, 3'd0, 5'd11, 7'h13));
        chk("mid_rst_qcount", 32'(bus.q_count), 32'd0);
        chk("mid_rst_ovf", 32'(bus.overflow), 32'd0);
        reset = 1'b1;
        fetch(enc_i(12'd0, 5'd1, 3'd0, 5'd3, 7'h13));
        idle_tick();
        chk("post_rst_qcount", 32'(bus.q_count), 32'd1);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            sel = int'($urandom_range(0, 7));
            w   = $urandom;
            unique case (sel)
                0: w = 32'h00000013;
                1, 2, 3: begin
                    w[6:0] = 7'h13;
                    hi = (($urandom & 3) == 0) ? 7'($urandom) :
                         (($urandom & 1) != 0) ? 7'h20 : 7'h00;
                    w[31:25] = hi;
                end
                4, 5: w[6:0] = 7'h03;
                6: ;
                default: w[6:0] = 7'h13;
            endcase
            bus.instr_valid  = ($urandom_range(0, 3) != 0);
            bus.instr        = w;
            bus.retire_valid = ($urandom_range(0, 1) != 0);
            bus.retire_wen   = ($urandom_range(0, 4) != 0);
            if (m_q.size() != 0 && $urandom_range(0, 3) != 0) bus.retire_rd = m_q[0];
            else bus.retire_rd = 5'($urandom);
            reset = ($urandom_range(0, 79) != 0);
            tick();
        end
        reset = 1'b1;
        idle_tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
